// File: rtl/vga_timing_if.sv
// Timing-generator output bundle plus its run enable.
// master = the generator, slave = the display consumer.
interface vga_timing_if #(
    parameter int unsigned CW = 10
);
    logic          en;
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        output en,
        input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y counters and registered sync/blank.
// Strobes (pix_tick, line_start, frame_start) are combinational from the divider.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter bit          H_POL   = 1'b0,
    parameter bit          V_POL   = 1'b0,
    parameter int unsigned CW      = 10
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master bus
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW    = 4;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
    localparam logic [CW-1:0] HS_START = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_q, video_d;
    logic          tick;

    // State register; reset lands on the first pixel of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            video_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    // Sync/blank are decoded from the next counter values so they move with x/y.
    always_comb begin
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        video_d = video_q;
        tick    = bus.en && !reset && (div_q == DIV_LAST);

        if (bus.en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
            hsync_d = (x_d >= HS_START && x_d <= HS_END) ? H_POL : ~H_POL;
            vsync_d = (y_d >= VS_START && y_d <= VS_END) ? V_POL : ~V_POL;
            video_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        end
    end

    assign bus.pix_tick    = tick;
    assign bus.line_start  = tick && (x_q == '0);
    assign bus.frame_start = tick && (x_q == '0) && (y_q == '0);
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_q;
    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL take these parameters, given as name, default, meaning:
  CLK_DIV, 4, system clocks per pixel (allowed 1..16)
  H_VIS, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, horizontal sync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_VIS, 480, visible lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vertical sync width (lines)
  V_BP, 33, vertical back porch (lines)
  H_POL, 0, hsync active level (0 = active-low)
  V_POL, 0, vsync active level (0 = active-low)
  CW, 10, pixel_x/pixel_y width; must satisfy 2^CW > max(H_TOT-1, V_TOT-1)
REQ-002 The block SHALL have these ports, given as name, direction, width, meaning:
  clk  in  1  system clock; one clock domain only
  reset  in  1  asynchronous, active-high reset
  en  in  1  run enable; low freezes all timing state
  pix_tick  out  1  pixel-rate strobe, one clk wide
  hsync  out  1  horizontal sync at H_POL
  vsync  out  1  vertical sync at V_POL
  video_on  out  1  high inside the visible area
  pixel_x  out  CW  current column
  pixel_y  out  CW  current row
  line_start  out  1  one-clk pulse at the start of a line
  frame_start  out  1  one-clk pulse at the start of a frame

Function
REQ-003 Derived totals SHALL be H_TOT = H_VIS+H_FP+H_SYNC+H_BP and V_TOT = V_VIS+V_FP+V_SYNC+V_BP, computed at elaboration with no truncation.
REQ-004 The divider SHALL count 0..CLK_DIV-1 while en=1.
REQ-005 pix_tick SHALL be high for the single clk cycle in which divider = CLK_DIV-1 and en=1; with CLK_DIV=1, pix_tick = en.
REQ-006 On each clk edge that samples pix_tick=1, pixel_x SHALL increment. At H_TOT-1 it SHALL wrap to 0.
REQ-007 pixel_y SHALL increment on each pixel_x wrap. At V_TOT-1 it SHALL wrap to 0 on the same edge.
REQ-008 hsync SHALL be at H_POL when pixel_x is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], and at ~H_POL otherwise.
REQ-009 vsync SHALL be at V_POL when pixel_y is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], and at ~V_POL otherwise.
REQ-010 video_on SHALL be high iff pixel_x < H_VIS and pixel_y < V_VIS.
REQ-011 hsync, vsync and video_on SHALL be registered and SHALL change on the same clk edge as pixel_x/pixel_y; there SHALL be zero skew between these five outputs.
REQ-012 line_start SHALL equal pix_tick and (pixel_x = 0).
REQ-013 frame_start SHALL equal pix_tick and (pixel_x = 0) and (pixel_y = 0).
REQ-014 While en=0, the divider, counters and all registered outputs SHALL hold their values, and pix_tick, line_start and frame_start SHALL be 0.
REQ-015 When en rises, the divider SHALL resume from its held value, with no extra or lost tick.

Reset
REQ-016 Asserting reset SHALL immediately, with no clk edge, set: divider = 0, pixel_x = 0, pixel_y = 0, video_on = 1, hsync = ~H_POL, vsync = ~V_POL, pix_tick/line_start/frame_start = 0.
REQ-017 Reset asserted mid-line or mid-frame SHALL abandon the frame; after release, timing SHALL restart at (0,0) with the first pix_tick CLK_DIV clk edges later.

Verification
REQ-018 Defaults, release reset with en=1 -> pix_tick on clk edges 4, 8, 12, ...; frame_start and line_start both high with the first pix_tick.
REQ-019 Defaults, run one line -> pixel_x wraps 799->0 as pixel_y goes 0->1; hsync is low for exactly 96 ticks (x = 656..751); video_on is high for x = 0..639.
REQ-020 Defaults, run a full frame -> 420000 ticks between frame_start pulses; vsync is low for lines 490..491 (1600 ticks); video_on is high for 307200 ticks.
REQ-021 Drop en for 50 clks at pixel_x = 100 -> no pix_tick during the gap, all outputs frozen, and pixel_x = 101 appears exactly CLK_DIV enabled clks after resuming.
REQ-022 Assert reset asynchronously at (300,200) between clk edges -> outputs take their REQ-016 values before the next clk edge.
REQ-023 CLK_DIV=1, H_POL=1, H = 8/2/2/2, V = 4/1/1/1 -> pix_tick every clk; hsync is high at x = 10..11; a frame is 98 clks.
